mux_n_to_1_reg: RTL and testbench

Parametrised, registered N-to-1 channel multiplexer for the single-clock CPU datapath. It supersedes the purely combinational 2-to-1 select mux wherever a source must be held across a stall. It selects one of CH input channels, by explicit select or round-robin, and captures it into a one-entry output register with a valid/ready handshake on every side. Typical uses are write-back source selection and shared-port arbitration in front of memory.

---
 rtl/mux_n_to_1_reg_pkg.sv | 13 +
 rtl/mux_n_to_1_reg_if.sv | 30 +++
 rtl/mux_n_to_1_reg_rr_arbiter.sv | 30 +++
 rtl/mux_n_to_1_reg.sv | 90 +++++++++
 tb/tb_mux_n_to_1_reg.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_n_to_1_reg_pkg.sv
// Shared constants and helpers for the registered N-to-1 channel multiplexer.
package mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;
   localparam int   CH_MAX   = 16;

   // Select/channel-ID width: clog2 of the channel count, never below one bit.
   function automatic int sel_w_f(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

endpackage

// File: rtl/mux_n_to_1_reg_if.sv
// Channel-side and output-side handshake bundle of mux_n_to_1_reg.
interface mux_n_to_1_reg_if
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CH    = 4,
   parameter int SEL_W = sel_w_f(CH)
) ();

   logic [CH*WIDTH-1:0] data_i;
   logic [CH-1:0]       valid_i;
   logic [CH-1:0]       ready_o;
   logic [SEL_W-1:0]    select_i;
   logic                mode_i;
   logic [WIDTH-1:0]    data_o;
   logic [SEL_W-1:0]    chan_o;
   logic                valid_o;
   logic                ready_i;

   modport master (
      output data_i, valid_i, select_i, mode_i, ready_i,
      input  ready_o, data_o, chan_o, valid_o
   );

   modport slave (
      input  data_i, valid_i, select_i, mode_i, ready_i,
      output ready_o, data_o, chan_o, valid_o
   );

endinterface

// File: rtl/mux_n_to_1_reg_rr_arbiter.sv
// Combinational rotate-priority search: first requester above ptr, wrapping modulo CH.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int CH    = 4,
   localparam int SEL_W = sel_w_f(CH)
) (
   input  logic [CH-1:0]    req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [SEL_W-1:0] gnt_idx
);

   logic [SEL_W-1:0] idx;

   // Walk from the farthest offset down so the nearest requester after ptr wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = '0;
      for (int i = CH; i >= 1; i--) begin
         idx = SEL_W'((int'(ptr) + i) % CH);
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/mux_n_to_1_reg.sv
// Registered N-to-1 channel mux with valid/ready on every side.
// Round-robin arbitration via mode_i is built only when MUX_RR_EN is defined.
module mux_n_to_1_reg
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CH    = 4,
   parameter int SEL_W = sel_w_f(CH)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   mux_n_to_1_reg_if.slave bus
);

   localparam int NPAD = 1 << SEL_W;

   logic [NPAD-1:0]  req_pad;
   logic             sel_hit;
   logic             grant;
   logic             load_en;
   logic             xfer_in;
   logic [SEL_W-1:0] g;
   logic [CH-1:0]    ready_d;
   logic [WIDTH-1:0] data_q;
   logic [SEL_W-1:0] chan_q;
   logic             valid_q;

   // Zero padding above CH makes an out-of-range select a miss instead of an alias.
   assign req_pad = NPAD'(bus.valid_i);
   assign sel_hit = req_pad[bus.select_i];
   assign load_en = !valid_q || bus.ready_i;
   assign xfer_in = grant && load_en && !rst_i;

`ifdef MUX_RR_EN
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] rr_idx;
   logic             rr_valid;
   logic             rr_mode;

   assign rr_mode = (bus.mode_i == MODE_RR);

   rr_arbiter #(.CH(CH)) u_rr_arbiter (
      .req       (bus.valid_i),
      .ptr       (rr_ptr),
      .gnt_valid (rr_valid),
      .gnt_idx   (rr_idx)
   );

   assign grant = rr_mode ? rr_valid : sel_hit;
   assign g     = rr_mode ? rr_idx   : bus.select_i;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         rr_ptr <= SEL_W'(CH - 1);
      else if (xfer_in && rr_mode)
         rr_ptr <= g;
   end
`else
   logic unused_mode;
   assign unused_mode = bus.mode_i;
   assign grant       = sel_hit;
   assign g           = bus.select_i;
`endif

   always_comb begin
      ready_d = '0;
      if (xfer_in)
         ready_d[g] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
      end else if (xfer_in) begin
         valid_q <= 1'b1;
         data_q  <= bus.data_i[int'(g)*WIDTH +: WIDTH];
         chan_q  <= g;
      end else if (bus.ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.ready_o = ready_d;
   assign bus.data_o  = data_q;
   assign bus.chan_o  = chan_q;
   assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Scoreboard bench for mux_n_to_1_reg: CH=4 random/directed plus CH=3 edge cases.
module tb_mux_n_to_1_reg;
   import mux_pkg::*;

`ifdef MUX_RR_EN
   localparam bit RR_ON = 1'b1;
`else
   localparam bit RR_ON = 1'b0;
`endif

   typedef struct {
      int         ch;
      logic [7:0] d;
   } item_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4 = 1'b1;
   logic rst3 = 1'b1;

   mux_n_to_1_reg_if #(.WIDTH(8), .CH(4)) b4 ();
   mux_n_to_1_reg_if #(.WIDTH(8), .CH(3)) b3 ();

   mux_n_to_1_reg #(.WIDTH(8), .CH(4)) dut4 (.clk_i(clk), .rst_i(rst4), .bus(b4));
   mux_n_to_1_reg #(.WIDTH(8), .CH(3)) dut3 (.clk_i(clk), .rst_i(rst3), .bus(b3));

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   logic [3:0] exp_ready4 = '0;
   logic       exp_valid4 = 1'b0;
   int         rr4 = 3;
   item_t      q4[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference rule: select mode takes select if in range and valid; RR takes first valid after ptr.
   function automatic int model_grant(int ch, logic [15:0] v, int sel, bit rr, int ptr);
      if (!rr) return (sel < ch && v[sel]) ? sel : -1;
      for (int i = 1; i <= ch; i++) begin
         if (v[(ptr + i) % ch]) return (ptr + i) % ch;
      end
      return -1;
   endfunction

   task automatic drive4(bit rst, logic [3:0] v, int sel, bit mode, bit rdy, logic [31:0] d);
      int  gr;
      bit  ev;
      @(posedge clk);
      #1;
      rst4         = rst;
      b4.data_i    = d;
      b4.valid_i   = v;
      b4.select_i  = 2'(sel);
      b4.mode_i    = mode;
      b4.ready_i   = rdy;
      ev           = (q4.size() != 0);
      exp_valid4   = ev;
      exp_ready4   = '0;
      if (rst) begin
         q4.delete();
         rr4 = 3;
      end else begin
         gr = model_grant(4, 16'(v), sel, mode && RR_ON, rr4);
         if (gr >= 0 && (!ev || rdy)) begin
            exp_ready4 = 4'(1 << gr);
            q4.push_back('{ch: gr, d: d[gr*8 +: 8]});
            if (mode && RR_ON) rr4 = gr;
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("valid4", 32'(b4.valid_o), 32'(exp_valid4));
         chk("ready4", 32'(b4.ready_o), 32'(exp_ready4));
         if (!rst4 && b4.valid_o) begin
            if (q4.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard4: got valid_o=1 expected empty queue at %0t", $time);
            end else begin
               chk("chan4", 32'(b4.chan_o), 32'(q4[0].ch));
               chk("data4", 32'(b4.data_o), 32'(q4[0].d));
               if (b4.ready_i) void'(q4.pop_front());
            end
         end
      end
   end

   localparam logic [31:0] D4 = 32'h13121110;

   initial begin
      logic [23:0] d3;
      logic [2:0]  v3;
      int          sel3, gr3, rr3, exp_ch3;
      bit          mode3, exp_v3;
      logic [7:0]  exp_d3;

      b4.data_i = '0; b4.valid_i = '0; b4.select_i = '0; b4.mode_i = 1'b0; b4.ready_i = 1'b0;
      b3.data_i = '0; b3.valid_i = '0; b3.select_i = '0; b3.mode_i = 1'b0; b3.ready_i = 1'b0;

      // ---------------- CH=4: reset, select, backpressure ----------------
      drive4(1, 4'hf, 2, 0, 1, D4);
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_data4", 32'(b4.data_o), 32'h0);
      drive4(1, 4'hf, 2, 0, 1, D4);
      @(negedge clk);
      chk("rst_chan4", 32'(b4.chan_o), 32'h0);
      chk("rst_ready4", 32'(b4.ready_o), 32'h0);
      drive4(0, 4'hf, 2, 0, 1, D4);
      @(negedge clk);
      chk("first_ready4", 32'(b4.ready_o), 32'h4);
      drive4(0, 4'hf, 0, 0, 0, D4);
      @(negedge clk);
      chk("held_data4", 32'(b4.data_o), 32'h12);
      chk("held_ready4", 32'(b4.ready_o), 32'h0);
      drive4(0, 4'hf, 0, 1, 0, D4);
      @(negedge clk);
      chk("held2_data4", 32'(b4.data_o), 32'h12);
      drive4(0, 4'hf, 0, 0, 1, D4);
      @(negedge clk);
      chk("swap_ready4", 32'(b4.ready_o), 32'h1);
      drive4(0, 4'h0, 0, 0, 1, D4);
      @(negedge clk);
      chk("swap_data4", 32'(b4.data_o), 32'h10);
      chk("swap_valid4", 32'(b4.valid_o), 32'h1);

      // ---------------- CH=4: round-robin fairness and skip ----------------
      for (int i = 0; i < 8; i++) drive4(0, 4'hf, 0, 1, 1, D4);
      drive4(0, 4'b0010, 1, 1, 1, D4);
      for (int i = 0; i < 4; i++) drive4(0, 4'b1010, 1, 1, 1, D4);

      // ---------------- CH=4: randomized ----------------
      for (int i = 0; i < 400; i++) begin
         drive4(($urandom_range(0, 49) == 0), 4'($urandom), $urandom_range(0, 3),
                1'($urandom), ($urandom_range(0, 3) != 0), $urandom);
      end
      drive4(0, 4'h0, 0, 0, 1, D4);
      drive4(0, 4'h0, 0, 0, 1, D4);
      @(negedge clk);
      mon_en = 1'b0;
      chk("drain4", 32'(q4.size()), 32'h0);

      // ---------------- CH=3: out-of-range select, reset while held ----------------
      d3 = 24'h333231;
      @(posedge clk); #1;
      rst3 = 1'b1; b3.valid_i = 3'b111; b3.select_i = 2'd3; b3.ready_i = 1'b1; b3.data_i = d3;
      @(posedge clk); #1;
      rst3 = 1'b0;
      @(negedge clk);
      chk("oor_ready3", 32'(b3.ready_o), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("oor_valid3", 32'(b3.valid_o), 32'h0);
      chk("oor_ready3b", 32'(b3.ready_o), 32'h0);
      @(posedge clk); #1;
      b3.select_i = 2'd1;
      @(negedge clk);
      chk("sel1_ready3", 32'(b3.ready_o), 32'h2);
      @(posedge clk); #1;
      b3.ready_i = 1'b0;
      @(negedge clk);
      chk("held_valid3", 32'(b3.valid_o), 32'h1);
      chk("held_data3", 32'(b3.data_o), 32'h32);
      @(posedge clk); #1;
      rst3 = 1'b1;
      @(negedge clk);
      chk("rst_ready3", 32'(b3.ready_o), 32'h0);
      @(posedge clk); #1;
      rst3 = 1'b0; b3.valid_i = 3'b000;
      @(negedge clk);
      chk("rst_valid3", 32'(b3.valid_o), 32'h0);

      // ---------------- CH=3: randomized, downstream always ready ----------------
      rr3 = 2; exp_v3 = 1'b0; exp_ch3 = 0; exp_d3 = '0;
      b3.ready_i = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         v3 = 3'($urandom); sel3 = $urandom_range(0, 3); mode3 = 1'($urandom); d3 = 24'($urandom);
         b3.valid_i = v3; b3.select_i = 2'(sel3); b3.mode_i = mode3; b3.data_i = d3;
         gr3 = model_grant(3, 16'(v3), sel3, mode3 && RR_ON, rr3);
         @(negedge clk);
         chk("valid3", 32'(b3.valid_o), 32'(exp_v3));
         if (exp_v3) begin
            chk("chan3", 32'(b3.chan_o), 32'(exp_ch3));
            chk("data3", 32'(b3.data_o), 32'(exp_d3));
         end
         chk("ready3", 32'(b3.ready_o), (gr3 >= 0) ? 32'(1 << gr3) : 32'h0);
         exp_v3 = (gr3 >= 0);
         if (gr3 >= 0) begin
            exp_ch3 = gr3;
            exp_d3  = d3[gr3*8 +: 8];
            if (mode3 && RR_ON) rr3 = gr3;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
